cla_mul_arbiter: RTL and testbench
==================================

CLA_MUL_ARBITER -- requirements
Module: cla_mul_arbiter

Interface
REQ-001 Parameter N, default 32, multicand width in bits.
REQ-002 Parameter M, default 32, multiplier width in bits.
REQ-003 Parameter REQS, default 4, number of requesters (power of two, >=2); IW = log2(REQS).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  REQS  per-requester request strobe.
REQ-007 req_ready  output  REQS  per-requester accept; at most one bit high per cycle.
REQ-008 req_multicand  input  REQS*N  packed operands; requester k occupies bits [k*N +: N].
REQ-009 req_multiplier  input  REQS*M  packed operands; requester k occupies bits [k*M +: M].
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  downstream accepts result.
REQ-012 rsp_product  output  N+M  unsigned product of granted operands.
REQ-013 rsp_id  output  IW  index of requester owning rsp_product.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Block SHALL time-share one combinational CLA multiplier among REQS requesters via FSM states IDLE, COMPUTE, RESPOND.
REQ-016 IDLE: if any req_valid high, grant = first requester with req_valid high searching upward (with wrap) from rr_ptr; req_ready[grant] high combinationally same cycle; operands and grant index registered; next state COMPUTE.
REQ-017 IDLE with no req_valid: all req_ready low, state unchanged.
REQ-018 req_ready SHALL be low in COMPUTE and RESPOND regardless of req_valid.
REQ-019 COMPUTE lasts exactly one cycle: multiplier driven from operand registers; product registered into rsp_product at its end; next state RESPOND.
REQ-020 RESPOND: rsp_valid high; rsp_product and rsp_id held stable until rsp_ready sampled high.
REQ-021 Handshake rsp_valid&&rsp_ready: rr_ptr <= (grant+1) mod REQS (wrap from REQS-1 to 0); next state IDLE; rsp_valid low next cycle.
REQ-022 Latency: request accepted in cycle T yields rsp_valid in cycle T+2; minimum issue interval 3 cycles with rsp_ready held high.
REQ-023 Product is unsigned, full width N+M, no truncation or saturation.
REQ-024 Request accept and response handshake never coincide (disjoint states); requesters deasserting req_valid before grant lose nothing and are not granted.
REQ-025 Requester holding req_valid high SHALL be granted within REQS accepted transactions (round-robin fairness).

Reset
REQ-026 rst high SHALL force state IDLE, rr_ptr 0, rsp_valid 0, rsp_product 0, rsp_id 0, busy 0, req_ready all 0 in the following cycle, regardless of current state.
REQ-027 Reset mid-COMPUTE or mid-RESPOND SHALL discard the in-flight transaction with no response emitted.
REQ-028 While rst is high, req_ready SHALL be all 0.

Structure
REQ-029 State encodings (IDLE=2'd0, COMPUTE=2'd1, RESPOND=2'd2) SHALL live in a shared header/package included by RTL and bench.
REQ-030 Existing CLA_Multiplier (ports product, multicand, multiplier; widths N, M) SHALL be instantiated as the sole sub-module; round-robin grant logic stays inline.
REQ-031 Estimated RTL size 150-250 lines.

Verification
REQ-032 Single request: req 0 presents 10, 12 -> req_ready[0] at T, rsp_valid at T+2, product 120, rsp_id 0.
REQ-033 Width check: 32'h0000FFFF x 32'h000000FF -> 64'h0000_0000_00FE_FF01; 32'hFFFFFFFF x 32'hFFFFFFFF -> 64'hFFFFFFFE_00000001.
REQ-034 Contention: all four req_valid held high from reset, operands k+1, k+2 -> grant order 0,1,2,3,0; products 2,6,12,20,2.
REQ-035 Backpressure: rsp_ready low 5 cycles during RESPOND -> rsp_valid, rsp_product, rsp_id stable; req_ready all 0; completes one cycle after rsp_ready rises.
REQ-036 Reset mid-COMPUTE (req 2, 1234 x 10) -> no rsp_valid; next request from req 0 granted first with rr_ptr 0, product correct.

Source files
------------

// File: rtl/cla_mul_arbiter_pkg.sv
// Shared definitions for the time-shared CLA multiplier arbiter.
// The state encoding is visible to both the design and its bench.
package cla_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/cla_mul_arbiter_cla.sv
// Combinational unsigned multiplier. Partial products are accumulated
// through a parallel-prefix carry-lookahead adder.
module CLA_Multiplier #(
  parameter int N = 32,
  parameter int M = 32
) (
  output logic [N+M-1:0] product,
  input  logic [N-1:0]   multicand,
  input  logic [M-1:0]   multiplier
);

  localparam int W = N + M;

  // Kogge-Stone prefix over generate/propagate; carry-in is zero, so the
  // carry into bit j is the group generate of bits j-1..0.
  function automatic logic [W-1:0] cla_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;
    p0 = x ^ y;
    g  = x & y;
    p  = p0;
    for (int d = 1; d < W; d = d * 2) begin
      g = g | (p & (g << d));
      p = p & (p << d);
    end
    return p0 ^ (g << 1);
  endfunction

  logic [W-1:0] w_acc;
  logic [W-1:0] w_mcand_ext;

  assign w_mcand_ext = {{M{1'b0}}, multicand};

  // Shift-and-add accumulation of partial products.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < M; i++) begin
      if (multiplier[i]) begin
        w_acc = cla_add(w_acc, w_mcand_ext << i);
      end else begin
        w_acc = w_acc;
      end
    end
  end

  assign product = w_acc;

endmodule

// File: rtl/cla_mul_arbiter.sv
// Round-robin arbiter sharing one combinational CLA multiplier among
// REQS requesters through an IDLE -> COMPUTE -> RESPOND sequence.
module cla_mul_arbiter
  import cla_mul_arbiter_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int M    = 32,
  parameter  int REQS = 4,
  localparam int IW   = $clog2(REQS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  input  logic [REQS*N-1:0] req_multicand,
  input  logic [REQS*M-1:0] req_multiplier,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N+M-1:0]    rsp_product,
  output logic [IW-1:0]     rsp_id,
  output logic              busy
);

  state_e          r_state;
  state_e          w_next_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   w_grant;
  logic            w_any;
  logic [N-1:0]    r_mcand;
  logic [M-1:0]    r_mplier;
  logic [N+M-1:0]  w_product;

  CLA_Multiplier #(.N(N), .M(M)) u_mul (
    .product    (w_product),
    .multicand  (r_mcand),
    .multiplier (r_mplier)
  );

  // Round-robin search: scan downward so the lowest offset from r_rr_ptr wins.
  always_comb begin
    logic [IW-1:0] v_idx;
    w_any   = 1'b0;
    w_grant = r_rr_ptr;
    v_idx   = r_rr_ptr;
    for (int i = REQS - 1; i >= 0; i--) begin
      v_idx = r_rr_ptr + IW'(i);
      if (req_valid[v_idx]) begin
        w_any   = 1'b1;
        w_grant = v_idx;
      end else begin
        w_any   = w_any;
      end
    end
  end

  // Next-state and accept strobe; accept is suppressed while reset is held.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !rst) begin
          w_next_state = ST_COMPUTE;
          req_ready    = REQS'(1) << w_grant;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_COMPUTE: w_next_state = ST_RESPOND;
      ST_RESPOND: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESPOND;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, operand capture, result register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant  <= w_grant;
            r_mcand  <= req_multicand[int'(w_grant)*N +: N];
            r_mplier <= req_multiplier[int'(w_grant)*M +: M];
          end
        end
        ST_COMPUTE: begin
          rsp_product <= w_product;
          rsp_id      <= r_grant;
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            r_rr_ptr <= r_grant + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_RESPOND);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cla_mul_arbiter.sv
// Self-checking bench: directed vector table, hand-written reset/contention
// sequences and randomized transactions against a round-robin model.
module tb_cla_mul_arbiter;
  import cla_mul_arbiter_pkg::*;

  localparam int N = 32;
  localparam int M = 32;
  localparam int REQS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = 4'd0;
  logic [3:0]    req_ready;
  logic [127:0]  req_multicand;
  logic [127:0]  req_multiplier;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [63:0]   rsp_product;
  logic [1:0]    rsp_id;
  logic          busy;

  logic [31:0]   a_op [4];
  logic [31:0]   b_op [4];

  int checks = 0;
  int errors = 0;
  int rr_model = 0;

  cla_mul_arbiter #(.N(N), .M(M), .REQS(REQS)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_multicand  (req_multicand),
    .req_multiplier (req_multiplier),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_product    (rsp_product),
    .rsp_id         (rsp_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_multicand[k*32 +: 32]  = a_op[k];
      req_multiplier[k*32 +: 32] = b_op[k];
    end
  end

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    logic [63:0] exp_p;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] mask, input int rr);
    for (int i = 0; i < 4; i++) begin
      if (mask[(rr + i) % 4]) return (rr + i) % 4;
    end
    return -1;
  endfunction

  // Starts and ends at a negedge with the DUT idle.
  task automatic run_txn(input logic [3:0] mask, input int delay,
                         input logic [63:0] exp_p, input logic [1:0] exp_id);
    if (mask == 4'd0) begin
      req_valid = 4'd0;
      #1 chk("idle_ready", 64'(req_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      return;
    end
    req_valid = mask;
    rsp_ready = 1'b0;
    #1;
    chk("grant", 64'(req_ready), 64'(4'd1 << exp_id));
    chk("busy_idle", 64'(busy), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("ready_compute", 64'(req_ready), 64'd0);
    chk("busy_compute", 64'(busy), 64'd1);
    chk("valid_compute", 64'(rsp_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_product", rsp_product, exp_p);
    chk("rsp_id", 64'(rsp_id), 64'(exp_id));
    chk("ready_respond", 64'(req_ready), 64'd0);
    for (int c = 0; c < delay; c++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_product", rsp_product, exp_p);
      chk("hold_id", 64'(rsp_id), 64'(exp_id));
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'd0;
    #1;
    chk("done_valid", 64'(rsp_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    rr_model = (int'(exp_id) + 1) % 4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'hF;
    #1 chk("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    req_valid = 4'd0;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", rsp_product, 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    rr_model = 0;
  endtask

  initial begin
    logic [63:0] e;
    int g;
    logic [3:0] mask;

    vecs[0] = '{4'b0001, 32'd10,         32'd12,         0, 64'd120,                  2'd0};
    vecs[1] = '{4'b0001, 32'h0000FFFF,   32'h000000FF,   0, 64'h0000_0000_00FE_FF01,  2'd0};
    vecs[2] = '{4'b1111, 32'hFFFFFFFF,   32'hFFFFFFFF,   0, 64'hFFFFFFFE_00000001,    2'd1};
    vecs[3] = '{4'b0001, 32'd0,          32'd12345,      5, 64'd0,                    2'd0};
    vecs[4] = '{4'b1000, 32'd7,          32'd9,          2, 64'd63,                   2'd3};
    vecs[5] = '{4'b0110, 32'd1,          32'd1,          0, 64'd1,                    2'd1};

    for (int k = 0; k < 4; k++) begin
      a_op[k] = 32'd0;
      b_op[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    do_reset();

    // Directed vectors, all requesters carry the same operands.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) begin
        a_op[k] = vecs[v].a;
        b_op[k] = vecs[v].b;
      end
      run_txn(vecs[v].mask, vecs[v].delay, vecs[v].exp_p, vecs[v].exp_id);
    end

    // Contention from reset: grant order 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_op[k] = 32'(k + 1);
      b_op[k] = 32'(k + 2);
    end
    run_txn(4'hF, 0, 64'd2,  2'd0);
    run_txn(4'hF, 0, 64'd6,  2'd1);
    run_txn(4'hF, 0, 64'd12, 2'd2);
    run_txn(4'hF, 0, 64'd20, 2'd3);
    run_txn(4'hF, 0, 64'd2,  2'd0);

    // Reset while in RESPOND drops the response.
    a_op[1] = 32'd5; b_op[1] = 32'd6;
    req_valid = 4'b0010;
    @(posedge clk); @(negedge clk);
    req_valid = 4'd0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_respond", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_respond_valid", 64'(rsp_valid), 64'd0);
    chk("rst_respond_product", rsp_product, 64'd0);

    // Reset while in COMPUTE: no response, pointer back to 0.
    run_txn(4'b0100, 0, 64'd12, 2'd2);
    a_op[2] = 32'd1234; b_op[2] = 32'd10;
    req_valid = 4'b0100;
    #1 chk("rst_c_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); @(negedge clk);
    req_valid = 4'd0;
    chk("rst_c_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_c_idle", 64'(busy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_c_norsp", 64'(rsp_valid), 64'd0);
    end
    rr_model = 0;
    a_op[0] = 32'd1234; b_op[0] = 32'd10;
    run_txn(4'hF, 0, 64'd12340, 2'd0);

    // Randomized transactions against the round-robin model.
    for (int t = 0; t < 60; t++) begin
      mask = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: a_op[k] = 32'hFFFFFFFF;
          default: a_op[k] = $urandom;
        endcase
        b_op[k] = $urandom;
      end
      g = model_grant(mask, rr_model);
      if (g < 0) begin
        run_txn(4'd0, 0, 64'd0, 2'd0);
      end else begin
        e = 64'(a_op[g]) * 64'(b_op[g]);
        run_txn(mask, int'($urandom_range(0, 3)), e, 2'(g));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
